// File: rtl/sram_flash_pad_arb.sv
// Arbiter for the shared sram_flash_* board pads between flash_cntrl (F) and zbt_cntrl (Z),
// with bus-turnaround idle cycles between owners and optional preemption of a long holder.
module sram_flash_pad_arb #(
  parameter int unsigned TURN_CYC = 2,
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        f_req_i,
  output logic        f_gnt_o,
  input  logic [20:0] f_addr_i,
  input  logic        f_we_n_i,
  input  logic [15:0] f_dat_i,
  input  logic        f_dat_oe_i,
  input  logic        z_req_i,
  output logic        z_gnt_o,
  input  logic [20:0] z_addr_i,
  input  logic        z_we_n_i,
  input  logic [3:0]  z_bw_i,
  input  logic [31:0] z_dat_i,
  input  logic        z_dat_oe_i,
  output logic [20:0] pad_addr_o,
  output logic        pad_we_n_o,
  output logic [3:0]  pad_bw_o,
  output logic [31:0] pad_dat_o,
  output logic        pad_dat_oe_o,
  output logic        pad_flash_ce2_o,
  output logic        pad_sram_cen_o
);

  localparam int unsigned HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);

  typedef enum logic [1:0] {IDLE, OWN_F, OWN_Z, TURN} state_t;
  typedef enum logic {SIDE_F, SIDE_Z} side_t;

  state_t            state, state_nxt;
  side_t             last_gnt, last_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [3:0]        turn_cnt, turn_nxt;
  logic [20:0]       last_addr;
  logic              own_req, oth_req, preempt;

  // Both requesting: the side that did not own the pads last time wins.
  function automatic state_t arbitrate(input logic f_req, input logic z_req, input side_t last);
    if (f_req && z_req) return (last == SIDE_Z) ? OWN_F : OWN_Z;
    if (f_req) return OWN_F;
    if (z_req) return OWN_Z;
    return IDLE;
  endfunction

  assign own_req = (state == OWN_F) ? f_req_i : z_req_i;
  assign oth_req = (state == OWN_F) ? z_req_i : f_req_i;
  assign preempt = (MAX_HOLD != 0) && oth_req && (hold_cnt == HOLD_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state    <= IDLE;
      f_gnt_o  <= 1'b0;
      z_gnt_o  <= 1'b0;
      last_gnt <= SIDE_Z;
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= state_nxt;
      f_gnt_o  <= (state_nxt == OWN_F);
      z_gnt_o  <= (state_nxt == OWN_Z);
      last_gnt <= last_nxt;
      hold_cnt <= hold_nxt;
      turn_cnt <= turn_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last_gnt;
    hold_nxt  = hold_cnt;
    turn_nxt  = turn_cnt;
    case (state)
      IDLE: state_nxt = arbitrate(f_req_i, z_req_i, last_gnt);
      OWN_F, OWN_Z: begin
        if (!own_req || preempt) begin
          state_nxt = TURN;
          hold_nxt  = '0;
          turn_nxt  = '0;
        end else if (oth_req && (hold_cnt != {HOLD_W{1'b1}})) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      TURN: begin
        if (turn_cnt == TURN_LAST) state_nxt = arbitrate(f_req_i, z_req_i, last_gnt);
        else turn_nxt = turn_cnt + 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == OWN_F) last_nxt = SIDE_F;
    else if (state_nxt == OWN_Z) last_nxt = SIDE_Z;
  end

  // Address seen on the pads during the last owned cycle; held through turnaround.
  always_ff @(posedge wb_clk_i) begin
    if (state == OWN_F) last_addr <= f_addr_i;
    else if (state == OWN_Z) last_addr <= z_addr_i;
  end

  always_comb begin
    pad_addr_o      = '0;
    pad_we_n_o      = 1'b1;
    pad_bw_o        = 4'hf;
    pad_dat_o       = '0;
    pad_dat_oe_o    = 1'b0;
    pad_flash_ce2_o = 1'b0;
    pad_sram_cen_o  = 1'b1;
    case (state)
      OWN_F: begin
        pad_addr_o      = f_addr_i;
        pad_we_n_o      = f_we_n_i;
        pad_dat_o       = {16'h0, f_dat_i};
        pad_dat_oe_o    = f_dat_oe_i;
        pad_flash_ce2_o = 1'b1;
      end
      OWN_Z: begin
        pad_addr_o     = z_addr_i;
        pad_we_n_o     = z_we_n_i;
        pad_bw_o       = z_bw_i;
        pad_dat_o      = z_dat_i;
        pad_dat_oe_o   = z_dat_oe_i;
        pad_sram_cen_o = 1'b0;
      end
      TURN: pad_addr_o = last_addr;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_flash_pad_arb.sv
// Directed and random checks of sram_flash_pad_arb; three instances with MAX_HOLD 64, 4 and 0.
module tb_sram_flash_pad_arb;

  localparam int DEF = 0;
  localparam int H4  = 1;
  localparam int H0  = 2;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i;
  logic        f_req_i, f_we_n_i, f_dat_oe_i;
  logic [20:0] f_addr_i;
  logic [15:0] f_dat_i;
  logic        z_req_i, z_we_n_i, z_dat_oe_i;
  logic [20:0] z_addr_i;
  logic [3:0]  z_bw_i;
  logic [31:0] z_dat_i;

  logic        f_gnt [3];
  logic        z_gnt [3];
  logic [20:0] pad_addr [3];
  logic        pad_we_n [3];
  logic [3:0]  pad_bw [3];
  logic [31:0] pad_dat [3];
  logic        pad_oe [3];
  logic        pad_ce2 [3];
  logic        pad_cen [3];

  int vectors = 0;
  int miscompares = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_flash_pad_arb #(
      .TURN_CYC(2),
      .MAX_HOLD((g == 0) ? 64 : (g == 1) ? 4 : 0)
    ) u_dut (
      .wb_clk_i       (wb_clk_i),
      .wb_rst_n_i     (wb_rst_n_i),
      .f_req_i        (f_req_i),
      .f_gnt_o        (f_gnt[g]),
      .f_addr_i       (f_addr_i),
      .f_we_n_i       (f_we_n_i),
      .f_dat_i        (f_dat_i),
      .f_dat_oe_i     (f_dat_oe_i),
      .z_req_i        (z_req_i),
      .z_gnt_o        (z_gnt[g]),
      .z_addr_i       (z_addr_i),
      .z_we_n_i       (z_we_n_i),
      .z_bw_i         (z_bw_i),
      .z_dat_i        (z_dat_i),
      .z_dat_oe_i     (z_dat_oe_i),
      .pad_addr_o     (pad_addr[g]),
      .pad_we_n_o     (pad_we_n[g]),
      .pad_bw_o       (pad_bw[g]),
      .pad_dat_o      (pad_dat[g]),
      .pad_dat_oe_o   (pad_oe[g]),
      .pad_flash_ce2_o(pad_ce2[g]),
      .pad_sram_cen_o (pad_cen[g])
    );
  end

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    f_req_i = 0; f_addr_i = '0; f_we_n_i = 1; f_dat_i = '0; f_dat_oe_i = 0;
    z_req_i = 0; z_addr_i = '0; z_we_n_i = 1; z_bw_i = 4'hf; z_dat_i = '0; z_dat_oe_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    wb_rst_n_i = 0;
    tick();
    tick();
    wb_rst_n_i = 1;
  endtask

  task automatic test_reset();
    logic [62:0] got, exp;
    f_req_i = 1; f_addr_i = 21'h1abcd; f_we_n_i = 0; f_dat_i = 16'h5555; f_dat_oe_i = 1;
    z_req_i = 1; z_addr_i = 21'h0f00f; z_we_n_i = 0; z_bw_i = 4'h0; z_dat_i = 32'h12345678; z_dat_oe_i = 1;
    wb_rst_n_i = 0;
    tick();
    tick();
    exp = {1'b0, 1'b0, 21'h0, 1'b1, 4'hf, 32'h0, 1'b0, 1'b0, 1'b1};
    for (int g = 0; g < 3; g++) begin
      got = {f_gnt[g], z_gnt[g], pad_addr[g], pad_we_n[g], pad_bw[g], pad_dat[g],
             pad_oe[g], pad_ce2[g], pad_cen[g]};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_state[%0d] got=%h exp=%h", g, got, exp);
      end
    end
    clear_inputs();
    wb_rst_n_i = 1;
    tick();
    vectors++;
    if ({f_gnt[DEF], z_gnt[DEF]} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_no_req gnts got=%b exp=00", {f_gnt[DEF], z_gnt[DEF]});
    end
  endtask

  task automatic test_grant_latency();
    do_reset();
    f_req_i = 1; f_addr_i = 21'h12345; f_we_n_i = 0; f_dat_i = 16'hbeef; f_dat_oe_i = 1;
    #1;
    vectors++;
    if ({f_gnt[DEF], pad_ce2[DEF], pad_oe[DEF]} !== 3'b000) begin
      miscompares++;
      $display("FAIL t1_pre_grant got=%b exp=000", {f_gnt[DEF], pad_ce2[DEF], pad_oe[DEF]});
    end
    tick();
    vectors++;
    if ({f_gnt[DEF], z_gnt[DEF], pad_ce2[DEF], pad_cen[DEF], pad_we_n[DEF], pad_oe[DEF], pad_bw[DEF]}
        !== {6'b101101, 4'hf}) begin
      miscompares++;
      $display("FAIL t1_grant_ctrl got=%b exp=%b",
               {f_gnt[DEF], z_gnt[DEF], pad_ce2[DEF], pad_cen[DEF], pad_we_n[DEF], pad_oe[DEF], pad_bw[DEF]},
               {6'b101101, 4'hf});
    end
    vectors++;
    if ({pad_addr[DEF], pad_dat[DEF]} !== {21'h12345, 32'h0000beef}) begin
      miscompares++;
      $display("FAIL t1_grant_data got=%h/%h exp=12345/0000beef", pad_addr[DEF], pad_dat[DEF]);
    end
    f_addr_i = 21'h0abcd;
    #1;
    vectors++;
    if (pad_addr[DEF] !== 21'h0abcd) begin
      miscompares++;
      $display("FAIL t1_addr_follow got=%h exp=0abcd", pad_addr[DEF]);
    end
    f_req_i = 0;
    tick();
    vectors++;
    if ({f_gnt[DEF], z_gnt[DEF], pad_oe[DEF], pad_we_n[DEF], pad_ce2[DEF], pad_cen[DEF], pad_addr[DEF]}
        !== {6'b000101, 21'h0abcd}) begin
      miscompares++;
      $display("FAIL t1_turn1 got=%b/%h exp=000101/0abcd",
               {f_gnt[DEF], z_gnt[DEF], pad_oe[DEF], pad_we_n[DEF], pad_ce2[DEF], pad_cen[DEF]}, pad_addr[DEF]);
    end
    tick();
    vectors++;
    if (pad_addr[DEF] !== 21'h0abcd) begin
      miscompares++;
      $display("FAIL t1_turn2_addr got=%h exp=0abcd", pad_addr[DEF]);
    end
    tick();
    vectors++;
    if ({f_gnt[DEF], pad_addr[DEF]} !== {1'b0, 21'h0}) begin
      miscompares++;
      $display("FAIL t1_back_idle got=%b/%h exp=0/000000", f_gnt[DEF], pad_addr[DEF]);
    end
  endtask

  task automatic test_regrant_same_side();
    do_reset();
    f_req_i = 1;
    tick();
    f_req_i = 0;
    tick();
    f_req_i = 1;
    tick();
    vectors++;
    if (f_gnt[DEF] !== 1'b0) begin
      miscompares++;
      $display("FAIL regrant_in_turn f_gnt got=%b exp=0", f_gnt[DEF]);
    end
    tick();
    vectors++;
    if (f_gnt[DEF] !== 1'b1) begin
      miscompares++;
      $display("FAIL regrant_after_turn f_gnt got=%b exp=1", f_gnt[DEF]);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    f_req_i = 1; f_we_n_i = 0; f_dat_oe_i = 1;
    z_req_i = 1; z_addr_i = 21'h1f0f0; z_we_n_i = 0; z_bw_i = 4'h5; z_dat_i = 32'hcafef00d; z_dat_oe_i = 1;
    tick();
    vectors++;
    if ({f_gnt[DEF], z_gnt[DEF], pad_ce2[DEF]} !== 3'b101) begin
      miscompares++;
      $display("FAIL t2_f_wins got=%b exp=101", {f_gnt[DEF], z_gnt[DEF], pad_ce2[DEF]});
    end
    repeat (3) tick();
    vectors++;
    if (f_gnt[DEF] !== 1'b1) begin
      miscompares++;
      $display("FAIL t2_f_holds got=%b exp=1", f_gnt[DEF]);
    end
    f_req_i = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if ({f_gnt[DEF], z_gnt[DEF], pad_oe[DEF], pad_we_n[DEF]} !== 4'b0001) begin
        miscompares++;
        $display("FAIL t2_turn%0d got=%b exp=0001", c, {f_gnt[DEF], z_gnt[DEF], pad_oe[DEF], pad_we_n[DEF]});
      end
    end
    tick();
    vectors++;
    if ({z_gnt[DEF], f_gnt[DEF], pad_ce2[DEF], pad_cen[DEF], pad_we_n[DEF], pad_oe[DEF], pad_bw[DEF]}
        !== {6'b100001, 4'h5}) begin
      miscompares++;
      $display("FAIL t2_z_grant got=%b exp=%b",
               {z_gnt[DEF], f_gnt[DEF], pad_ce2[DEF], pad_cen[DEF], pad_we_n[DEF], pad_oe[DEF], pad_bw[DEF]},
               {6'b100001, 4'h5});
    end
    vectors++;
    if ({pad_addr[DEF], pad_dat[DEF]} !== {21'h1f0f0, 32'hcafef00d}) begin
      miscompares++;
      $display("FAIL t2_z_data got=%h/%h exp=1f0f0/cafef00d", pad_addr[DEF], pad_dat[DEF]);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    z_req_i = 1; z_we_n_i = 0;
    tick();
    vectors++;
    if (z_gnt[H4] !== 1'b1) begin
      miscompares++;
      $display("FAIL t3_z_grant got=%b exp=1", z_gnt[H4]);
    end
    repeat (9) tick();
    f_req_i = 1;
    repeat (3) tick();
    vectors++;
    if (z_gnt[H4] !== 1'b1) begin
      miscompares++;
      $display("FAIL t3_before_preempt z_gnt got=%b exp=1", z_gnt[H4]);
    end
    tick();
    vectors++;
    if ({z_gnt[H4], f_gnt[H4], pad_we_n[H4], z_gnt[DEF]} !== 4'b0011) begin
      miscompares++;
      $display("FAIL t3_preempt got=%b exp=0011", {z_gnt[H4], f_gnt[H4], pad_we_n[H4], z_gnt[DEF]});
    end
    tick();
    vectors++;
    if ({f_gnt[H4], pad_oe[H4]} !== 2'b00) begin
      miscompares++;
      $display("FAIL t3_turn2 got=%b exp=00", {f_gnt[H4], pad_oe[H4]});
    end
    tick();
    vectors++;
    if ({f_gnt[H4], z_gnt[H4]} !== 2'b10) begin
      miscompares++;
      $display("FAIL t3_f_grant got=%b exp=10", {f_gnt[H4], z_gnt[H4]});
    end
    repeat (4) tick();
    vectors++;
    if (f_gnt[H4] !== 1'b0) begin
      miscompares++;
      $display("FAIL t3_f_preempted got=%b exp=0", f_gnt[H4]);
    end
    repeat (2) tick();
    vectors++;
    if ({z_gnt[H4], z_gnt[DEF]} !== 2'b11) begin
      miscompares++;
      $display("FAIL t3_z_regrant got=%b exp=11", {z_gnt[H4], z_gnt[DEF]});
    end
  endtask

  task automatic test_no_preempt();
    int lost = 0;
    do_reset();
    z_req_i = 1;
    tick();
    f_req_i = 1;
    repeat (200) begin
      tick();
      if (z_gnt[H0] !== 1'b1) lost++;
    end
    vectors++;
    if (lost !== 0) begin
      miscompares++;
      $display("FAIL t4_hold lost_cycles got=%0d exp=0", lost);
    end
    z_req_i = 0;
    tick();
    vectors++;
    if ({z_gnt[H0], f_gnt[H0]} !== 2'b00) begin
      miscompares++;
      $display("FAIL t4_release got=%b exp=00", {z_gnt[H0], f_gnt[H0]});
    end
    tick();
    vectors++;
    if (f_gnt[H0] !== 1'b0) begin
      miscompares++;
      $display("FAIL t4_turn2 f_gnt got=%b exp=0", f_gnt[H0]);
    end
    tick();
    vectors++;
    if (f_gnt[H0] !== 1'b1) begin
      miscompares++;
      $display("FAIL t4_f_grant got=%b exp=1", f_gnt[H0]);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    z_req_i = 1; z_we_n_i = 0; z_dat_oe_i = 1; z_bw_i = 4'h0; z_addr_i = 21'h00777;
    tick();
    vectors++;
    if ({z_gnt[DEF], pad_cen[DEF], pad_we_n[DEF]} !== 3'b100) begin
      miscompares++;
      $display("FAIL t5_writing got=%b exp=100", {z_gnt[DEF], pad_cen[DEF], pad_we_n[DEF]});
    end
    #2;
    wb_rst_n_i = 0;
    #1;
    vectors++;
    if ({z_gnt[DEF], pad_we_n[DEF], pad_cen[DEF], pad_oe[DEF], pad_ce2[DEF], pad_bw[DEF], pad_addr[DEF]}
        !== {5'b01100, 4'hf, 21'h0}) begin
      miscompares++;
      $display("FAIL t5_async_drop got=%b/%h exp=01100/f/000000",
               {z_gnt[DEF], pad_we_n[DEF], pad_cen[DEF], pad_oe[DEF], pad_ce2[DEF]}, pad_bw[DEF]);
    end
    tick();
    wb_rst_n_i = 1;
    z_req_i = 0; f_req_i = 1;
    #1;
    vectors++;
    if (f_gnt[DEF] !== 1'b0) begin
      miscompares++;
      $display("FAIL t5_pre_grant got=%b exp=0", f_gnt[DEF]);
    end
    tick();
    vectors++;
    if ({f_gnt[DEF], pad_ce2[DEF]} !== 2'b11) begin
      miscompares++;
      $display("FAIL t5_first_grant got=%b exp=11", {f_gnt[DEF], pad_ce2[DEF]});
    end
  endtask

  task automatic test_random();
    int dual = 0;
    int oe_bad = 0;
    int turn_bad = 0;
    int f_wait = 0;
    int z_wait = 0;
    int max_wait = 0;
    int idle_run [3];
    int last_own [3];
    do_reset();
    for (int g = 0; g < 3; g++) begin
      idle_run[g] = 0;
      last_own[g] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      if (!f_req_i) f_req_i = ($urandom_range(0, 3) == 0);
      else if (f_gnt[H4] && ($urandom_range(0, 5) == 0)) f_req_i = 0;
      if (!z_req_i) z_req_i = ($urandom_range(0, 3) == 0);
      else if (z_gnt[H4] && ($urandom_range(0, 5) == 0)) z_req_i = 0;
      f_addr_i = 21'($urandom); f_we_n_i = 1'($urandom); f_dat_i = 16'($urandom); f_dat_oe_i = 1'($urandom);
      z_addr_i = 21'($urandom); z_we_n_i = 1'($urandom); z_bw_i = 4'($urandom);
      z_dat_i = $urandom; z_dat_oe_i = 1'($urandom);
      tick();
      for (int g = 0; g < 3; g++) begin
        int own;
        own = f_gnt[g] ? 1 : (z_gnt[g] ? 2 : 0);
        if (f_gnt[g] && z_gnt[g]) dual++;
        if (own == 0) begin
          if (pad_oe[g] || !pad_we_n[g]) oe_bad++;
          idle_run[g]++;
        end else begin
          if (last_own[g] != 0 && last_own[g] != own && idle_run[g] < 2) turn_bad++;
          idle_run[g] = 0;
          last_own[g] = own;
        end
      end
      if (f_req_i && !f_gnt[H4]) f_wait++; else f_wait = 0;
      if (z_req_i && !z_gnt[H4]) z_wait++; else z_wait = 0;
      if (f_wait > max_wait) max_wait = f_wait;
      if (z_wait > max_wait) max_wait = z_wait;
    end
    vectors++;
    if (dual !== 0) begin
      miscompares++;
      $display("FAIL t6_dual_grant cycles got=%0d exp=0", dual);
    end
    vectors++;
    if (oe_bad !== 0) begin
      miscompares++;
      $display("FAIL t6_pads_active_ungranted cycles got=%0d exp=0", oe_bad);
    end
    vectors++;
    if (turn_bad !== 0) begin
      miscompares++;
      $display("FAIL t6_short_turnaround events got=%0d exp=0", turn_bad);
    end
    vectors++;
    if (max_wait > 16) begin
      miscompares++;
      $display("FAIL t6_starvation max_wait got=%0d exp<=16", max_wait);
    end
  endtask

  initial begin
    clear_inputs();
    wb_rst_n_i = 1;
    test_reset();
    test_grant_latency();
    test_regrant_same_side();
    test_simultaneous();
    test_preempt();
    test_no_preempt();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
